// File: rtl/inst_fetch_buffer_pkg.sv
// Shared bus widths, constants and the prefetch entry layout for the instruction fetch buffer.
package inst_fetch_buffer_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_WORD    = '0;
    localparam logic [INST_ADDR_W-1:0] ZERO_ADDR    = '0;
    localparam logic                   CHIP_ENABLE  = 1'b1;
    localparam logic                   CHIP_DISABLE = 1'b0;
    localparam logic [INST_ADDR_W-1:0] INST_STRIDE  = INST_ADDR_W'(4);

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return addr & ~INST_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch storage: DEPTH-entry synchronous FIFO of {pc, inst} with flush, count and head read-out.
module fetch_fifo
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head_entry
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_entry;
    end

    assign head_entry = mem[head_ptr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch: fetches sequential words from a combinational ROM into a small FIFO
// and hands them to decode; a branch redirect flushes the buffer and restarts fetch.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [INST_ADDR_W-1:0] RESET_PC = '0,
    localparam int                    CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0]      rom_data_i,
    input  logic                   id_ready_i,
    output logic                   if_valid_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic [CNT_W-1:0]       dbg_count
);

    // Decode handshake: the head transfers on every rising edge where if_valid_o and
    // id_ready_i are both high; if_valid_o never depends on id_ready_i.

    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]       count;
    logic                   pop;
    logic                   buf_full;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;

    assign if_valid_o = (count != '0);
    assign pop        = if_valid_o && id_ready_i;
    assign buf_full   = (count == CNT_W'(DEPTH));

    // rst gates the enable directly so fetch stops the instant reset is asserted.
    assign rom_ce_o   = (rst && !branch_flag_i && (!buf_full || pop)) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr_o = (rom_ce_o == CHIP_ENABLE) ? fetch_pc : ZERO_ADDR;

    assign push_entry = '{pc: fetch_pc, inst: rom_data_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (branch_flag_i) begin
            fetch_pc <= word_align(branch_target_i);
        end else if (rom_ce_o == CHIP_ENABLE) begin
            fetch_pc <= fetch_pc + INST_STRIDE;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .flush      (branch_flag_i),
        .push       (rom_ce_o),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head_entry (head_entry)
    );

    assign if_inst_o = if_valid_o ? head_entry.inst : ZERO_WORD;
    assign if_pc_o   = if_valid_o ? head_entry.pc   : ZERO_ADDR;
    assign dbg_count = count;

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rom_ce_o  output  1  instruction ROM chip enable; high means a fetch this cycle.
REQ-006 rom_addr_o  output  `InstAddrBus (32)  byte address to ROM.
REQ-007 rom_data_i  input  `InstBus (32)  ROM read data; combinational, valid in the same cycle as rom_addr_o while rom_ce_o is high.
REQ-008 id_ready_i  input  1  decode stage accepts the head instruction this cycle.
REQ-009 if_valid_o  output  1  head entry holds a valid instruction.
REQ-010 if_inst_o  output  `InstBus (32)  head instruction.
REQ-011 if_pc_o  output  `InstAddrBus (32)  address of head instruction.
REQ-012 branch_flag_i  input  1  redirect request from execute.
REQ-013 branch_target_i  input  `InstAddrBus (32)  redirect address.

Function
REQ-014 Pop occurs when if_valid_o and id_ready_i are both high at a clock edge.
REQ-015 rom_ce_o is high iff rst is deasserted, branch_flag_i is low, and (count < DEPTH or a pop occurs this cycle).
REQ-016 rom_addr_o equals fetch_pc whenever rom_ce_o is high, and 0 otherwise.
REQ-017 Push: on an edge with rom_ce_o high, {fetch_pc, rom_data_i} is written at the tail and fetch_pc advances by 4.
REQ-018 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-019 Simultaneous push and pop leaves count unchanged, including at count == DEPTH.
REQ-020 if_valid_o = (count != 0); if_inst_o and if_pc_o present the head entry when valid, and 0 when empty.
REQ-021 Zero-latency bypass is not provided; an instruction is visible on if_*_o one cycle after its push edge.
REQ-022 Redirect: on an edge with branch_flag_i high, count clears, head/tail pointers reset, fetch_pc loads {branch_target_i[31:2], 2'b00}; no push that cycle.
REQ-023 Redirect has priority over push and pop; a pop completing in the redirect cycle counts as consumed.
REQ-024 A redirect held high for N cycles suppresses fetch for all N cycles; fetch resumes the cycle after deassertion.
REQ-025 With id_ready_i low and the buffer full, rom_ce_o stays low and the contents are held unchanged.
REQ-026 Instruction order out equals fetch order; no entry is lost or duplicated except those discarded by a redirect.

Reset
REQ-027 While rst is low: fetch_pc = RESET_PC, count = 0, pointers = 0, if_valid_o = 0, if_inst_o = 0, if_pc_o = 0, rom_ce_o = 0, rom_addr_o = 0.
REQ-028 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
REQ-029 On the first edge after rst deasserts, fetch from RESET_PC is permitted.

Structure
REQ-030 Bus widths `InstAddrBus and `InstBus, plus ZeroWord, ChipEnable/ChipDisable, live in the shared defines include; no local width literals.
REQ-031 Storage is one sub-module, fetch_fifo: DEPTH x 64-bit synchronous FIFO with push, pop, flush, count, head data.
REQ-032 fetch_pc register and ROM-enable logic stay in inst_fetch_buffer.

Verification
REQ-033 Reset release, id_ready_i=1, ROM word = addr: if_pc_o/if_inst_o show 0x0, 0x4, 0x8 on consecutive cycles, starting the second cycle after release.
REQ-034 id_ready_i=0 for 10 cycles: exactly 4 pushes (addresses 0x0 to 0xC), then rom_ce_o=0; head stays 0x0; raising ready drains 0x0..0xC in order.
REQ-035 Full buffer with id_ready_i=1: push and pop every cycle, count stays 4, rom_ce_o stays 1.
REQ-036 branch_flag_i=1, target 0x0000_0103, with 3 entries buffered: next cycle if_valid_o=0; first instruction after redirect has if_pc_o=0x100.
REQ-037 Redirect to 0xFFFF_FFF8: fetched addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 rst pulled low between edges with 2 entries buffered: if_valid_o=0 and rom_ce_o=0 immediately; after release, fetch restarts at RESET_PC.
